// File: rtl/elevator_request_scheduler_pkg.sv
// Shared types and default sizing for the elevator request scheduler.
package elevator_pkg;

    localparam int NUM_FLOORS_DEF = 9;
    localparam int FLOOR_W_DEF    = 4;

    typedef logic [FLOOR_W_DEF-1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2,
        DWELL = 2'd3
    } sched_state_t;

endpackage

// File: rtl/elevator_request_scheduler_btn_sync_edge.sv
// Two-flop synchroniser per bit followed by a one-cycle rising-edge pulse,
// so a held button yields exactly one request.
module btn_sync_edge
    import elevator_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN-policy request scheduler: latches call-button presses, picks the next
// target floor for the movement FSM and times the door dwell at each stop.
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
    parameter int FLOOR_W      = FLOOR_W_DEF,
    parameter int DWELL_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  idle,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  dir_up
);

    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    sched_state_t          state_q, state_d;
    logic                  last_up_q, last_up_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic                  door_q, door_d;
    logic                  dir_up_q, dir_up_d;
    logic [DW_W-1:0]       dwell_q, dwell_d;

    logic [NUM_FLOORS-1:0] rise, set_mask, clr_mask, here_mask;
    logic                  floor_ok, has_above, has_below, arrived;
    logic [FLOOR_W-1:0]    near_floor, low_above, high_below;

    btn_sync_edge #(.WIDTH(NUM_FLOORS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (call_btn),
        .rise  (rise)
    );

    function automatic logic [NUM_FLOORS-1:0] rel_mask(input logic [FLOOR_W-1:0] cf,
                                                       input int sel);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (sel > 0)      m[i] = (i > int'(cf));
            else if (sel < 0) m[i] = (i < int'(cf));
            else              m[i] = (i == int'(cf));
        end
        return m;
    endfunction

    function automatic logic [FLOOR_W-1:0] lowest_above(input logic [NUM_FLOORS-1:0] p,
                                                        input logic [FLOOR_W-1:0] cf);
        logic [FLOOR_W-1:0] res;
        res = cf;
        for (int i = NUM_FLOORS - 1; i >= 0; i--)
            if (p[i] && i > int'(cf)) res = FLOOR_W'(i);
        return res;
    endfunction

    function automatic logic [FLOOR_W-1:0] highest_below(input logic [NUM_FLOORS-1:0] p,
                                                         input logic [FLOOR_W-1:0] cf);
        logic [FLOOR_W-1:0] res;
        res = cf;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (p[i] && i < int'(cf)) res = FLOOR_W'(i);
        return res;
    endfunction

    // Ascending scan with <= lets the higher floor win a distance tie.
    function automatic logic [FLOOR_W-1:0] nearest(input logic [NUM_FLOORS-1:0] p,
                                                   input logic [FLOOR_W-1:0] cf);
        logic [FLOOR_W-1:0] res;
        int best, d;
        res  = cf;
        best = NUM_FLOORS + 1;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            d = (i > int'(cf)) ? i - int'(cf) : int'(cf) - i;
            if (p[i] && d <= best) begin
                best = d;
                res  = FLOOR_W'(i);
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        last_up_d = last_up_q;
        pending_d = pending_q;
        target_d  = target_q;
        door_d    = door_q;
        dwell_d   = dwell_q;
        clr_mask  = '0;

        floor_ok   = int'(current_floor) < NUM_FLOORS;
        here_mask  = rel_mask(current_floor, 0);
        has_above  = |(pending_q & rel_mask(current_floor, 1));
        has_below  = |(pending_q & rel_mask(current_floor, -1));
        near_floor = nearest(pending_q, current_floor);
        low_above  = lowest_above(pending_q, current_floor);
        high_below = highest_below(pending_q, current_floor);
        arrived    = idle && (current_floor == target_q) && |(pending_q & here_mask);

        // A press for the floor the car is parked at is already satisfied.
        set_mask = rise;
        if ((state_q == IDLE || state_q == DWELL) && idle)
            set_mask = rise & ~here_mask;

        if (floor_ok) begin
            case (state_q)
                IDLE: begin
                    target_d = current_floor;
                    if (pending_q != '0) begin
                        target_d = near_floor;
                        state_d  = (near_floor > current_floor) ? UP : DOWN;
                    end
                end
                UP, DOWN: begin
                    if (arrived) begin
                        clr_mask  = here_mask;
                        door_d    = 1'b1;
                        dwell_d   = DW_W'(DWELL_CYCLES - 1);
                        last_up_d = (state_q == UP);
                        state_d   = DWELL;
                    end else if (state_q == UP ? has_above : has_below) begin
                        target_d = (state_q == UP) ? low_above : high_below;
                    end else if (state_q == UP ? has_below : has_above) begin
                        target_d = (state_q == UP) ? high_below : low_above;
                        state_d  = (state_q == UP) ? DOWN : UP;
                    end else if (pending_q == '0) begin
                        target_d = current_floor;
                        state_d  = IDLE;
                    end
                end
                DWELL: begin
                    target_d = current_floor;
                    if (dwell_q == '0) begin
                        door_d = 1'b0;
                        if (last_up_q ? has_above : has_below)
                            state_d = last_up_q ? UP : DOWN;
                        else if (last_up_q ? has_below : has_above)
                            state_d = last_up_q ? DOWN : UP;
                        else
                            state_d = IDLE;
                    end else begin
                        dwell_d = dwell_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            pending_d = (pending_q | set_mask) & ~clr_mask;
        end

        dir_up_d = (state_d == UP);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            last_up_q <= 1'b0;
            pending_q <= '0;
            target_q  <= '0;
            door_q    <= 1'b0;
            dir_up_q  <= 1'b0;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_up_q <= last_up_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            door_q    <= door_d;
            dir_up_q  <= dir_up_d;
            dwell_q   <= dwell_d;
        end
    end

    assign target_floor = target_q;
    assign pending      = pending_q;
    assign door_open    = door_q;
    assign dir_up       = dir_up_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler with hand-computed expectations.
module tb_elevator_request_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [8:0] call_btn = '0;
    logic [3:0] current_floor = '0;
    logic       idle = 1'b1;
    logic [3:0] target_floor;
    logic [8:0] pending;
    logic       door_open;
    logic       dir_up;

    int total = 0;
    int bad = 0;
    int door_cycles;

    elevator_request_scheduler #(
        .NUM_FLOORS   (9),
        .FLOOR_W      (4),
        .DWELL_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .call_btn      (call_btn),
        .current_floor (current_floor),
        .idle          (idle),
        .target_floor  (target_floor),
        .pending       (pending),
        .door_open     (door_open),
        .dir_up        (dir_up)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single-cycle press; the request lands in pending after the third edge.
    task automatic press(input logic [8:0] mask);
        call_btn = mask;
        tick();
        call_btn = '0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
    endtask

    initial begin
        // Reset state
        current_floor = 4'd0;
        idle = 1'b1;
        tick();
        tick();
        check("rst_pending", 32'(pending), 32'h000);
        check("rst_target", 32'(target_floor), 32'd0);
        check("rst_door", 32'(door_open), 32'd0);
        check("rst_dir", 32'(dir_up), 32'd0);
        rst_n = 1'b0;

        // 1: press floor 5 from floor 0, serve it, full dwell
        call_btn = 9'h020;
        tick();
        call_btn = '0;
        check("t1_pend_c1", 32'(pending), 32'h000);
        tick();
        check("t1_pend_c2", 32'(pending), 32'h000);
        tick();
        check("t1_pend_c3", 32'(pending), 32'h020);
        check("t1_tgt_c3", 32'(target_floor), 32'd0);
        tick();
        check("t1_tgt_c4", 32'(target_floor), 32'd5);
        check("t1_dir_c4", 32'(dir_up), 32'd1);
        current_floor = 4'd5;
        tick();
        check("t1_arr_pend", 32'(pending), 32'h000);
        check("t1_arr_door", 32'(door_open), 32'd1);
        door_cycles = 0;
        for (int i = 0; i < 24; i++) begin
            if (door_open) door_cycles++;
            tick();
        end
        check("t1_door_len", 32'(door_cycles), 32'd16);
        check("t1_idle_tgt", 32'(target_floor), 32'd5);
        check("t1_idle_dir", 32'(dir_up), 32'd0);

        // 4: tie at floor 4 between 2 and 6 goes upward
        current_floor = 4'd4;
        idle = 1'b1;
        do_reset();
        press(9'h044);
        check("t4_pend", 32'(pending), 32'h044);
        check("t4_tgt_hold", 32'(target_floor), 32'd4);
        tick();
        check("t4_tgt", 32'(target_floor), 32'd6);
        check("t4_dir", 32'(dir_up), 32'd1);

        // 2: intermediate stop inserted while travelling up
        current_floor = 4'd2;
        idle = 1'b1;
        do_reset();
        press(9'h080);
        tick();
        check("t2_tgt7", 32'(target_floor), 32'd7);
        idle = 1'b0;
        press(9'h010);
        check("t2_pend", 32'(pending), 32'h090);
        check("t2_tgt_still7", 32'(target_floor), 32'd7);
        tick();
        check("t2_tgt4", 32'(target_floor), 32'd4);
        current_floor = 4'd3;
        tick();
        current_floor = 4'd4;
        idle = 1'b1;
        tick();
        check("t2_arr_pend", 32'(pending), 32'h080);
        check("t2_arr_door", 32'(door_open), 32'd1);
        repeat (16) tick();
        check("t2_exit_door", 32'(door_open), 32'd0);
        check("t2_exit_dir", 32'(dir_up), 32'd1);
        check("t2_exit_tgt", 32'(target_floor), 32'd4);
        tick();
        check("t2_resume_tgt", 32'(target_floor), 32'd7);

        // 3: at floor 6 heading up, only requests behind remain -> reverse
        current_floor = 4'd0;
        idle = 1'b1;
        do_reset();
        press(9'h040);
        tick();
        current_floor = 4'd6;
        tick();
        check("t3_arr_door", 32'(door_open), 32'd1);
        press(9'h00A);
        check("t3_pend", 32'(pending), 32'h00A);
        repeat (13) tick();
        check("t3_rev_door", 32'(door_open), 32'd0);
        check("t3_rev_dir", 32'(dir_up), 32'd0);
        tick();
        check("t3_tgt3", 32'(target_floor), 32'd3);
        current_floor = 4'd3;
        tick();
        check("t3_arr3_pend", 32'(pending), 32'h002);
        repeat (16) tick();
        tick();
        check("t3_tgt1", 32'(target_floor), 32'd1);
        check("t3_dir_down", 32'(dir_up), 32'd0);

        // 5: held button gives one request; dwell-floor press ignored
        current_floor = 4'd0;
        idle = 1'b0;
        do_reset();
        call_btn = 9'h008;
        repeat (3) tick();
        check("t5_pend_held", 32'(pending), 32'h008);
        tick();
        check("t5_tgt3", 32'(target_floor), 32'd3);
        repeat (6) tick();
        current_floor = 4'd3;
        idle = 1'b1;
        tick();
        check("t5_arr_pend", 32'(pending), 32'h000);
        repeat (19) tick();
        current_floor = 4'd5;
        idle = 1'b0;
        repeat (20) tick();
        check("t5_single_req", 32'(pending), 32'h000);
        call_btn = '0;
        idle = 1'b1;
        press(9'h010);
        check("t5_pend4", 32'(pending), 32'h010);
        tick();
        check("t5_tgt4", 32'(target_floor), 32'd4);
        current_floor = 4'd4;
        tick();
        check("t5_dwell_door", 32'(door_open), 32'd1);
        press(9'h010);
        check("t5_dwell_ignore", 32'(pending), 32'h000);
        press(9'h001);
        check("t5_dwell_accum", 32'(pending), 32'h001);

        // 6: asynchronous reset in the middle of a dwell
        current_floor = 4'd0;
        idle = 1'b1;
        do_reset();
        press(9'h002);
        tick();
        current_floor = 4'd1;
        tick();
        press(9'h1F0);
        check("t6_pend_pre", 32'(pending), 32'h1F0);
        check("t6_door_pre", 32'(door_open), 32'd1);
        #3;
        rst_n = 1'b1;
        #1;
        check("t6_async_pend", 32'(pending), 32'h000);
        check("t6_async_door", 32'(door_open), 32'd0);
        check("t6_async_tgt", 32'(target_floor), 32'd0);
        check("t6_async_dir", 32'(dir_up), 32'd0);
        #2;
        rst_n = 1'b0;
        current_floor = 4'd0;
        repeat (6) tick();
        check("t6_post_pend", 32'(pending), 32'h000);
        check("t6_post_door", 32'(door_open), 32'd0);
        check("t6_post_tgt", 32'(target_floor), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
Upstream stage of elevator_state_machine. Latches asynchronous call-button presses into a pending-request bitmap and selects the next target floor with a SCAN (elevator) policy: keep travelling in the current direction while requests remain ahead, then reverse. Drives requested_floor of the movement FSM and consumes its current_floor and idle status. Holds a door-dwell interval at each served floor.

Parameters:
NUM_FLOORS, 9, floors 0..NUM_FLOORS-1; max 16.
FLOOR_W, 4, width of floor indices.
DWELL_CYCLES, 16, clk cycles the door stays open after arrival; minimum 1.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset; asynchronous, active-high (asserted when 1)
call_btn  input  NUM_FLOORS  raw button levels; bit i requests floor i; asynchronous to clk
current_floor  input  FLOOR_W  floor reported by the movement FSM
idle  input  1  1 = movement FSM stationary (its idle output)
target_floor  output  FLOOR_W  registered floor request to the movement FSM
pending  output  NUM_FLOORS  registered outstanding-request bitmap
door_open  output  1  1 during dwell
dir_up  output  1  1 when the scheduler state is UP

Behaviour:
- Reset (rst_n=1, async): pending=0, target_floor=0, door_open=0, dir_up=0, state=IDLE, dwell counter=0, synchroniser flops=0.
- Input path: per bit, 2-flop synchroniser, then rising-edge detect. Press-to-pending latency is 3 cycles. A held button produces one request only.
- Set rule: edge on bit i sets pending[i]. It is ignored when state is IDLE or DWELL and current_floor==i and idle=1, because the car is already there.
- Clear rule: a clear and a set of the same bit in the same cycle resolve to clear.
- States: IDLE, UP, DOWN, DWELL (enum in the package).
- IDLE:
  - pending==0: stay; target_floor=current_floor.
  - Otherwise pick the nearest pending floor. On a distance tie, the higher floor wins.
  - Go to UP if the chosen floor > current_floor, else DOWN.
- UP: target = lowest pending floor > current_floor.
  - If none exist but some pending floor < current_floor: switch to DOWN with target = highest pending floor below.
- DOWN: mirror image of UP (highest pending floor below; reverse to lowest pending floor above).
- Arrival: UP or DOWN, idle=1, current_floor==target_floor, pending[target_floor]=1.
  - Clear that bit, door_open<=1, load dwell counter with DWELL_CYCLES-1, enter DWELL.
  - direction is remembered.
- DWELL:
  - target_floor holds current_floor; requests keep accumulating.
  - Counter decrements each cycle.
  - At 0: door_open<=0; next state is the remembered direction if requests remain ahead, the reversed direction if requests remain only behind, else IDLE.
- Request for the dwell floor during DWELL: ignored (set rule above).
- target_floor and dir_up are registered. They update the cycle after the state or pending change that causes them.
- Requests added ahead mid-travel: a nearer request in the travel direction replaces the target the next cycle (car stops at the intermediate floor).
- current_floor >= NUM_FLOORS: no set/clear/arrival is evaluated; state and target hold.
- Reset mid-operation: all pending requests are discarded; no partial dwell survives.

Decomposition:
- Package elevator_pkg:
  - sched_state_t enum (IDLE, UP, DOWN, DWELL).
  - NUM_FLOORS_DEF and FLOOR_W_DEF constants.
  - floor_t typedef.
- Sub-module btn_sync_edge: parameterised width, 2-flop synchroniser plus rising-edge pulse, same clk/rst_n.
- Floor-search logic (lowest above / highest below / nearest) stays as functions inside the scheduler.

Test Plan:
1. Reset, then pulse call_btn[5] for 1 cycle, current_floor=0, idle=1.
   -> pending=0x020 at cycle 3; target_floor=5 and dir_up=1 at cycle 4.
   -> Drive current_floor=5, idle=1: pending=0, door_open=1 for exactly 16 cycles, then IDLE.
2. At floor 2 travelling UP to 7, press floor 4.
   -> target_floor changes 7->4 one cycle after pending[4] sets.
   -> After arriving at 4 and dwelling, target returns to 7.
3. At floor 6 in UP, pending={1,3} only.
   -> Reverse to DOWN with target_floor=3, dir_up=0; after 3, target becomes 1.
4. IDLE at floor 4, pending {2,6} set in the same cycle.
   -> Tie resolves upward: target_floor=6, dir_up=1.
5. Hold call_btn[3] high for 50 cycles, and press the current floor while in DWELL.
   -> Single pending[3] set; the dwell-floor press leaves pending unchanged.
6. Assert rst_n=1 mid-DWELL with pending=0x1F0, asynchronously between clock edges.
   -> All outputs are 0 immediately; after release, no request reappears.
